// File: rtl/keypad_login.sv
// ------------------------------------------------------------------------
// keypad_login: debounced keypad PIN entry, PIN check and lockout.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module keypad_login #(
  parameter int                   DEBOUNCE_CYCLES = 4,
  parameter int                   PIN_LEN         = 4,
  parameter logic [4*PIN_LEN-1:0] PIN             = 16'h1234,
  parameter int                   MAX_TRIES       = 3,
  parameter int                   LOCK_CYCLES     = 1000,
  parameter int                   ENTRY_TIMEOUT   = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad,
  input  logic       logout,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [2:0] digit_count,
  output logic       granted,
  output logic       denied,
  output logic       locked
);

  localparam int BUF_W = 4 * PIN_LEN;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ET_W  = $clog2(ENTRY_TIMEOUT + 1);
  localparam int LT_W  = $clog2(LOCK_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ET_W-1:0] ET_LAST    = ET_W'(ENTRY_TIMEOUT - 1);
  localparam logic [LT_W-1:0] LT_LAST    = LT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]      PIN_LEN_C  = 3'(PIN_LEN);
  localparam logic [2:0]      MAX_TRY_C  = 3'(MAX_TRIES);
  localparam logic [3:0]      K_ZERO     = 4'hA;
  localparam logic [3:0]      K_CLEAR    = 4'hE;
  localparam logic [3:0]      K_ENTER    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_DENY, S_GRANT, S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sample_q, sample_d;
  logic [DB_W-1:0]   stable_q, stable_d;
  logic [3:0]        deb_q, deb_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [2:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        tries_q, tries_d;
  logic [ET_W-1:0]   etmr_q, etmr_d;
  logic [LT_W-1:0]   ltmr_q, ltmr_d;

  logic              is_digit;
  logic [3:0]        digit;
  logic [2:0]        tries_inc;
  logic              match;

  // Debounce: the filtered value follows the raw sample only after it has
  // been stable long enough; a press is a 0 -> nonzero filtered transition.
  always_comb begin
    sample_d = keypad;
    stable_d = stable_q;
    deb_d    = deb_q;
    if (keypad != sample_q) begin
      stable_d = '0;
    end else if (stable_q == DB_LAST) begin
      deb_d = sample_q;
    end else begin
      stable_d = stable_q + 1'b1;
    end
    key_valid_d = (deb_d != 4'h0) && (deb_q == 4'h0);
    key_code_d  = key_valid_d ? deb_d : key_code_q;
  end

  assign is_digit  = ((key_code_q >= 4'h1) && (key_code_q <= 4'h9)) || (key_code_q == K_ZERO);
  assign digit     = (key_code_q == K_ZERO) ? 4'h0 : key_code_q;
  assign tries_inc = tries_q + 3'd1;
  assign match     = (count_q == PIN_LEN_C) && !ovf_q && (buf_q == PIN);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    tries_d = tries_q;
    etmr_d  = etmr_q;
    ltmr_d  = ltmr_q;
    case (state_q)
      S_IDLE: begin
        if (key_valid_q && is_digit) begin
          buf_d   = BUF_W'(digit);
          count_d = 3'd1;
          ovf_d   = 1'b0;
          etmr_d  = '0;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_valid_q) begin
          etmr_d = '0;
          if (is_digit) begin
            if (count_q < PIN_LEN_C) begin
              buf_d   = (buf_q << 4) | BUF_W'(digit);
              count_d = count_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (key_code_q == K_CLEAR) begin
            buf_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
          end else if (key_code_q == K_ENTER) begin
            state_d = S_CHECK;
          end
        end else if (etmr_q == ET_LAST) begin
          // Abandoned entry behaves exactly like a clear key.
          buf_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          etmr_d  = '0;
          state_d = S_IDLE;
        end else begin
          etmr_d = etmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        buf_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        if (match) begin
          tries_d = '0;
          state_d = S_GRANT;
        end else begin
          tries_d = tries_inc;
          ltmr_d  = '0;
          state_d = (tries_inc == MAX_TRY_C) ? S_LOCKED : S_DENY;
        end
      end
      S_DENY: state_d = S_IDLE;
      S_GRANT: begin
        if (logout) state_d = S_IDLE;
      end
      S_LOCKED: begin
        if (ltmr_q == LT_LAST) begin
          ltmr_d  = '0;
          tries_d = '0;
          state_d = S_IDLE;
        end else begin
          ltmr_d = ltmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      stable_q    <= '0;
      deb_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      buf_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      tries_q     <= '0;
      etmr_q      <= '0;
      ltmr_q      <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      stable_q    <= stable_d;
      deb_q       <= deb_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      tries_q     <= tries_d;
      etmr_q      <= etmr_d;
      ltmr_q      <= ltmr_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign digit_count = count_q;
  assign granted     = (state_q == S_GRANT);
  assign locked      = (state_q == S_LOCKED);
  assign denied      = (state_q == S_DENY) || ((state_q == S_LOCKED) && (ltmr_q == '0));

endmodule

`default_nettype wire

// File: tb/tb_keypad_login.sv
// ------------------------------------------------------------------------
// tb_keypad_login: directed vector bench for keypad_login.         Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_keypad_login;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keypad = 4'h0;
  logic       logout = 1'b0;
  logic       key_valid, granted, denied, locked;
  logic [3:0] key_code;
  logic [2:0] digit_count;

  int passed = 0;
  int total  = 0;
  int kv_cnt = 0, den_cnt = 0, lock_cnt = 0;
  int base_kv, base_den, base_lock, n;

  typedef struct {
    logic [31:0] keys;     // first key in the top nibble
    int          nkeys;
    int          exp_den;
    int          exp_granted;
    int          exp_dc;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  keypad_login #(
    .DEBOUNCE_CYCLES(4),
    .PIN_LEN        (4),
    .PIN            (16'h1234),
    .MAX_TRIES      (3),
    .LOCK_CYCLES    (100),
    .ENTRY_TIMEOUT  (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad     (keypad),
    .logout     (logout),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .digit_count(digit_count),
    .granted    (granted),
    .denied     (denied),
    .locked     (locked)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) kv_cnt++;
      if (denied)    den_cnt++;
      if (locked)    lock_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    keypad = k;
    repeat (6) @(negedge clk);
    keypad = 4'h0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic press_seq(input logic [31:0] keys, input int cnt);
    for (int j = 0; j < cnt; j++) press(keys[31-4*j -: 4]);
  endtask

  task automatic do_logout();
    @(negedge clk);
    logout = 1'b1;
    @(negedge clk);
    logout = 1'b0;
    #1;
    check("logout_granted", granted, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1234F000, 5, 0, 1, 0};
    vecs[1] = '{32'h1235F000, 5, 1, 0, 0};
    vecs[2] = '{32'h12344F00, 6, 1, 0, 0};
    vecs[3] = '{32'h12E1234F, 8, 0, 1, 0};
    vecs[4] = '{32'h12000000, 2, 0, 0, 2};
    vecs[5] = '{32'hE0000000, 1, 0, 0, 0};
    vecs[6] = '{32'hD0000000, 1, 0, 0, 0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_key_valid",   key_valid,   0);
    check("rst_key_code",    key_code,    0);
    check("rst_digit_count", digit_count, 0);
    check("rst_granted",     granted,     0);
    check("rst_denied",      denied,      0);
    check("rst_locked",      locked,      0);
    @(negedge clk);
    rst = 1'b0;

    // Short glitch, then a clean hold with exact event timing.
    base_kv = kv_cnt;
    @(negedge clk);
    keypad = 4'h1;
    repeat (3) @(negedge clk);
    keypad = 4'h0;
    repeat (5) @(negedge clk);
    #1;
    check("glitch_no_event", kv_cnt - base_kv, 0);
    keypad = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("db_valid_edge%0d", k), key_valid, (k == 5) ? 1 : 0);
      if (k == 5) check("db_code", key_code, 1);
    end
    keypad = 4'h0;
    repeat (6) @(negedge clk);
    #1;
    check("db_one_event", kv_cnt - base_kv, 1);
    check("db_digit_count", digit_count, 1);
    press(4'hE);
    check("clear_digit_count", digit_count, 0);

    // Correct login with digit count stepping and grant latency.
    for (int i = 1; i <= 4; i++) begin
      press(4'(i));
      check($sformatf("login_dc%0d", i), digit_count, i);
    end
    @(negedge clk);
    keypad = 4'hF;
    n = 0;
    while (!key_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("enter_event_seen", key_valid, 1);
    @(negedge clk);
    #1;
    check("grant_after_1", granted, 0);
    @(negedge clk);
    #1;
    check("grant_after_2", granted, 1);
    keypad = 4'h0;
    repeat (6) @(negedge clk);
    do_logout();

    for (int v = 0; v < 7; v++) begin
      base_den = den_cnt;
      press_seq(vecs[v].keys, vecs[v].nkeys);
      check($sformatf("vec%0d_granted", v), granted, vecs[v].exp_granted);
      check($sformatf("vec%0d_dc", v), digit_count, vecs[v].exp_dc);
      check($sformatf("vec%0d_denied", v), den_cnt - base_den, vecs[v].exp_den);
      check($sformatf("vec%0d_locked", v), locked, 0);
      check($sformatf("vec%0d_code", v), key_code, int'(vecs[v].keys[31-4*(vecs[v].nkeys-1) -: 4]));
      if (vecs[v].exp_granted != 0) do_logout();
    end

    // Entry timeout abandons a partial PIN.
    press(4'h1);
    press(4'h2);
    repeat (180) @(negedge clk);
    #1;
    check("timeout_before", digit_count, 2);
    repeat (20) @(negedge clk);
    #1;
    check("timeout_after", digit_count, 0);

    // Lockout after three failures; a correct PIN inside it is ignored.
    base_den = den_cnt;
    press_seq(32'h1235F000, 5);
    press_seq(32'h1235F000, 5);
    base_lock = lock_cnt;
    press_seq(32'h1235F000, 5);
    check("lock_denied_cnt", den_cnt - base_den, 3);
    check("lock_active", locked, 1);
    base_kv = kv_cnt;
    press_seq(32'h1234F000, 5);
    check("lock_ignored_grant", granted, 0);
    check("lock_still_active", locked, 1);
    check("lock_key_valid_cnt", kv_cnt - base_kv, 5);
    check("lock_dc", digit_count, 0);
    n = 0;
    while (locked && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("lock_released", locked, 0);
    check("lock_duration", lock_cnt - base_lock, 100);
    check("lock_denied_total", den_cnt - base_den, 3);
    press_seq(32'h1234F000, 5);
    check("post_lock_grant", granted, 1);
    do_logout();

    // Reset during an open session.
    press_seq(32'h1234F000, 5);
    check("pre_reset_grant", granted, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_granted",   granted,     0);
    check("reset_locked",    locked,      0);
    check("reset_denied",    denied,      0);
    check("reset_key_valid", key_valid,   0);
    check("reset_key_code",  key_code,    0);
    check("reset_dc",        digit_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
